receive_frame: RTL and testbench
================================

# receive_frame

Serial frame receiver for the sensor-data link. Reassembles the 12-bit LSB-first frame that `send_frame` shifts out on its `data_out` wire, using the same clock and enable. It presents the frame in parallel with a one-cycle valid strobe, and pulses done at the end of each 101-cycle frame period. It sits between the link wire and the sensor FSM's consumer logic.

## Interface
Parameters:
- `FRAME_BITS`, 12: payload bits per frame.
- `FRAME_LAST`, 100: terminal count of the period counter. The period is `FRAME_LAST+1` enabled cycles.

Ports:
- `clk`, in, 1: single clock. All logic is on the rising edge.
- `rst_n`, in, 1: asynchronous active-low reset.
- `en_receive_frame`, in, 1: tied to the transmitter's `en_send_frame`. Low freezes all state.
- `data_in`, in, 1: serial line, driven by the transmitter's `data_out`.
- `frame_out`, out, `FRAME_BITS`: last complete frame. Bit 0 is the first bit received.
- `frame_valid`, out, 1: one-cycle pulse when `frame_out` updates.
- `done_receiving_frame`, out, 1: one-cycle pulse at the end of the period.
- `idle_error`, out, 1: only present when `RX_FRAME_IDLE_CHECK_EN` is defined.

## Operation
- Period counter `cnt`:
  - Width is `$clog2(FRAME_LAST+1)`, i.e. 7 bits.
  - Advances by 1 only on enabled cycles.
  - At `FRAME_LAST` it wraps to 0.
- FSM states (registered, decoded from `cnt`):
  - `IDLE` (`cnt==0`) → `SHIFT` on the first enabled edge.
  - `SHIFT` (`cnt` from 1 to `FRAME_BITS`): on each enabled edge, `data_in` is written to `shreg[cnt-1]`.
  - `SHIFT` → `GAP` after the edge with `cnt==FRAME_BITS`.
  - `GAP` (`cnt` from `FRAME_BITS+1` to `FRAME_LAST`) → `IDLE` on the enabled edge with `cnt==FRAME_LAST`.
- Sampling alignment: the transmitter drives bit k during the cycle after its count k. The receiver therefore samples bit k on its edge with `cnt==k+1`.
- Frame capture: on the enabled edge with `cnt==FRAME_BITS`:
  - `frame_out` is loaded with the full shift register, including the bit sampled on that same edge.
  - `frame_valid` is 1 for the following cycle.
- Done: on the enabled edge with `cnt==FRAME_LAST`, `done_receiving_frame` is 1 for the following cycle and `cnt` returns to 0.
- `en_receive_frame` low:
  - `cnt`, the state and `shreg` hold.
  - `frame_valid` and `done_receiving_frame` drop to 0 after the next edge.
  - `frame_out` holds.
  - The frame resumes exactly where it stopped.
- Back-to-back frames: the edge after `cnt==FRAME_LAST` is `cnt==0`. Nothing is sampled on that edge, and the next frame's bit 0 is sampled at `cnt==1`.

## Timing
- Reset values: `cnt`=0, state `IDLE`, `shreg`=0, `frame_out`=0, `frame_valid`=0, `done_receiving_frame`=0, `idle_error`=0.
- Reset asserted mid-frame clears everything immediately; the partial frame is discarded. After release, the first enabled edge is `cnt==0`.
- Latency from the first enabled edge (E0) with continuous enable:
  - `frame_valid` is high during the cycle after E12.
  - `done_receiving_frame` is high during the cycle after E100.
- `frame_valid` and `done_receiving_frame` are never high in the same cycle for the default parameters.
- Required parameter constraint: `FRAME_LAST > FRAME_BITS`.

## Configuration
Macro: `RX_FRAME_IDLE_CHECK_EN`.
- Defined:
  - Every `GAP` sample of `data_in` must be 0.
  - A 1 sets a sticky `err_seen` flag.
  - At the `cnt==FRAME_LAST` edge, `idle_error` registers `err_seen` for one cycle, alongside done, and `err_seen` clears.
- Undefined:
  - The `idle_error` port and its logic are absent.
  - `data_in` is ignored outside `SHIFT`.

## Structure
- Package `frame_link_pkg` holds:
  - `FRAME_BITS` and `FRAME_LAST` defaults, shared with `send_frame`.
  - The state enum `rx_state_t` with values `IDLE`, `SHIFT`, `GAP`.
- No sub-module. The receiver is a single module containing the counter, FSM and shift register.

## Test plan
- Pair with `send_frame`, frame=12'hA5C, continuous enable → `frame_out`=12'hA5C, with `frame_valid` in the cycle after E12 and done in the cycle after E100.
- Two back-to-back frames, 12'h001 then 12'h800 → two valid pulses 101 cycles apart with the correct values. No bit from the idle gap may leak into the second frame.
- Deassert enable for 5 cycles after E6 with frame 12'hFFF → `frame_out`=12'hFFF, and every event is delayed by exactly 5 cycles.
- Assert `rst_n`=0 at E8 of frame 12'h3C3, then run a clean frame 12'h555 → `frame_out` reaches 12'h555 with no `frame_valid` for the aborted frame.
- With `RX_FRAME_IDLE_CHECK_EN`, force `data_in`=1 at E50 → `idle_error` pulses together with done. The next clean frame gives `idle_error`=0.
- Without the macro, the same stimulus gives `frame_out` unchanged and no error output.

Source files
------------

// File: rtl/frame_link_pkg.sv
// frame_link_pkg: frame-link defaults shared by send_frame and receive_frame,
// plus the receiver state encoding.
package frame_link_pkg;
   localparam int FRAME_BITS = 12;
   localparam int FRAME_LAST = 100;
   typedef enum logic [1:0] {IDLE, SHIFT, GAP} rx_state_t;
endpackage

// File: rtl/receive_frame_if.sv
// receive_frame_if: link-side and consumer-side signals of receive_frame.
// idle_error exists only when RX_FRAME_IDLE_CHECK_EN is defined.
interface receive_frame_if
   import frame_link_pkg::*;
#(
   parameter int FRAME_BITS = frame_link_pkg::FRAME_BITS
);
   logic                  en_receive_frame;
   logic                  data_in;
   logic [FRAME_BITS-1:0] frame_out;
   logic                  frame_valid;
   logic                  done_receiving_frame;
`ifdef RX_FRAME_IDLE_CHECK_EN
   logic                  idle_error;
   modport master (
      output en_receive_frame, data_in,
      input  frame_out, frame_valid, done_receiving_frame, idle_error
   );
   modport slave (
      input  en_receive_frame, data_in,
      output frame_out, frame_valid, done_receiving_frame, idle_error
   );
`else
   modport master (
      output en_receive_frame, data_in,
      input  frame_out, frame_valid, done_receiving_frame
   );
   modport slave (
      input  en_receive_frame, data_in,
      output frame_out, frame_valid, done_receiving_frame
   );
`endif
endinterface

// File: rtl/receive_frame.sv
// receive_frame: reassembles the LSB-first serial frame from send_frame and pulses done each period.
// Optional RX_FRAME_IDLE_CHECK_EN flags any 1 sampled during the idle gap.
module receive_frame #(
   parameter int FRAME_BITS = frame_link_pkg::FRAME_BITS,
   parameter int FRAME_LAST = frame_link_pkg::FRAME_LAST
) (
   input logic            clk,
   input logic            rst_n,
   receive_frame_if.slave bus
);
   import frame_link_pkg::*;
   localparam int CW = $clog2(FRAME_LAST + 1);
   localparam logic [CW-1:0] BITS_C = CW'(FRAME_BITS);
   localparam logic [CW-1:0] LAST_C = CW'(FRAME_LAST);
   rx_state_t             state, state_nx;
   logic [CW-1:0]         cnt, cnt_nx;
   logic [FRAME_BITS-1:0] shreg, shreg_nx;
   logic                  en, at_last, capture;
   assign en      = bus.en_receive_frame;
   assign at_last = en && cnt == LAST_C;
   assign capture = en && state == SHIFT && cnt == BITS_C;
   always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      shreg_nx = shreg;
      if (en) begin
         cnt_nx   = at_last ? '0 : cnt + 1'b1;
         state_nx = state == IDLE ? SHIFT :
                    state == SHIFT && cnt == BITS_C ? GAP :
                    state == GAP && cnt == LAST_C ? IDLE : state;
         // the transmitter lags one cycle, so bit i arrives on the edge with cnt == i+1
         for (int i = 0; i < FRAME_BITS; i++)
            if (state == SHIFT && cnt == CW'(i + 1)) shreg_nx[i] = bus.data_in;
      end
   end
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state                    <= IDLE;
         cnt                      <= '0;
         shreg                    <= '0;
         bus.frame_out            <= '0;
         bus.frame_valid          <= 1'b0;
         bus.done_receiving_frame <= 1'b0;
      end else begin
         state                    <= state_nx;
         cnt                      <= cnt_nx;
         shreg                    <= shreg_nx;
         if (capture) bus.frame_out <= shreg_nx;
         bus.frame_valid          <= capture;
         bus.done_receiving_frame <= at_last;
      end
`ifdef RX_FRAME_IDLE_CHECK_EN
   logic err_seen, gap_hit;
   assign gap_hit = en && state == GAP && bus.data_in;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         err_seen       <= 1'b0;
         bus.idle_error <= 1'b0;
      end else begin
         err_seen       <= at_last ? 1'b0 : err_seen | gap_hit;
         bus.idle_error <= at_last && (err_seen || gap_hit);
      end
`endif
endmodule

// File: tb/tb_receive_frame.sv
// tb_receive_frame: table-driven frame scenarios, corner sequences and random
// stimulus checked every cycle against a queue-based model of the frame link.
module tb_receive_frame;
   import frame_link_pkg::*;
   typedef struct {
      logic [11:0] frame;
      int          stall_at;
      int          stall_len;
      logic [11:0] exp_frame;
      int          exp_valid;
      int          exp_done;
   } vec_t;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int compared = 0;
   int mismatched = 0;
   int edge_no, v_edge, d_edge, v_count, i_edge;
   int pos;
   logic q[$];
   logic [FRAME_BITS-1:0] m_frame;
   logic m_valid, m_done, m_err_seen, m_idle;
   vec_t vecs[4];
   receive_frame_if #(.FRAME_BITS(FRAME_BITS)) bus();
   receive_frame #(.FRAME_BITS(FRAME_BITS), .FRAME_LAST(FRAME_LAST)) dut (
      .clk(clk),
      .rst_n(rst_n),
      .bus(bus)
   );
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("FAIL %s: got 0x%0h, want 0x%0h (edge %0d)", name, act, exp, edge_no);
      end
   endtask

   task automatic check_outputs(input string tag);
      check({tag, "_frame_out"}, 32'(bus.frame_out), 32'(m_frame));
      check({tag, "_frame_valid"}, 32'(bus.frame_valid), 32'(m_valid));
      check({tag, "_done"}, 32'(bus.done_receiving_frame), 32'(m_done));
`ifdef RX_FRAME_IDLE_CHECK_EN
      check({tag, "_idle_error"}, 32'(bus.idle_error), 32'(m_idle));
`endif
   endtask

   task automatic model_reset();
      pos = 0;
      q.delete();
      m_frame = '0;
      m_valid = 1'b0;
      m_done = 1'b0;
      m_err_seen = 1'b0;
      m_idle = 1'b0;
   endtask

   // pos = number of enabled edges since reset, modulo the period length
   task automatic model_edge(input logic en, input logic d);
      m_valid = 1'b0;
      m_done = 1'b0;
      m_idle = 1'b0;
      if (en) begin
         if (pos >= 1 && pos <= FRAME_BITS) q.push_back(d);
         if (pos > FRAME_BITS && d) m_err_seen = 1'b1;
         if (pos == FRAME_BITS) begin
            for (int i = 0; i < FRAME_BITS; i++) m_frame[i] = q[i];
            q.delete();
            m_valid = 1'b1;
         end
         if (pos == FRAME_LAST) begin
            m_done = 1'b1;
            m_idle = m_err_seen;
            m_err_seen = 1'b0;
         end
         pos = (pos + 1) % (FRAME_LAST + 1);
      end
   endtask

   task automatic step(input logic en, input logic d);
      bus.en_receive_frame = en;
      bus.data_in = d;
      @(posedge clk);
      model_edge(en, d);
      edge_no++;
      #1;
      if (bus.frame_valid) begin
         v_edge = edge_no;
         v_count++;
      end
      if (bus.done_receiving_frame) d_edge = edge_no;
`ifdef RX_FRAME_IDLE_CHECK_EN
      if (bus.idle_error) i_edge = edge_no;
`endif
      check_outputs("cyc");
   endtask

   task automatic do_reset();
      #2 rst_n = 1'b0;
      bus.en_receive_frame = 1'b0;
      bus.data_in = 1'b0;
      model_reset();
      #1 check_outputs("reset");
      @(negedge clk) rst_n = 1'b1;
      edge_no = -1;
      v_edge = -1;
      d_edge = -1;
      i_edge = -1;
      v_count = 0;
   endtask

   // emulates send_frame: bit k is on the wire while the receiver sees cnt == k+1
   task automatic run_frame(input logic [11:0] f, input int stall_at, input int stall_len, input int force_at);
      for (int e = 0; e <= FRAME_LAST; e++) begin
         step(1'b1, (e >= 1 && e <= FRAME_BITS) ? f[e-1] : logic'(e == force_at));
         if (e == stall_at) repeat (stall_len) step(1'b0, 1'($urandom_range(0, 1)));
      end
   endtask

   initial begin
      logic [11:0] f3 = 12'h3C3;
      vecs[0] = '{12'hA5C, -1, 0, 12'hA5C, 12, 100};
      vecs[1] = '{12'hFFF,  6, 5, 12'hFFF, 17, 105};
      vecs[2] = '{12'h001, -1, 0, 12'h001, 12, 100};
      vecs[3] = '{12'h800,  3, 2, 12'h800, 14, 102};
      foreach (vecs[i]) begin
         do_reset();
         run_frame(vecs[i].frame, vecs[i].stall_at, vecs[i].stall_len, -1);
         check("vec_frame", 32'(bus.frame_out), 32'(vecs[i].exp_frame));
         check("vec_valid_edge", v_edge, vecs[i].exp_valid);
         check("vec_done_edge", d_edge, vecs[i].exp_done);
         check("vec_valid_count", v_count, 1);
      end
      // back-to-back frames with a stray 1 in the gap and on the cnt==0 edge
      do_reset();
      run_frame(12'h001, -1, 0, 50);
`ifdef RX_FRAME_IDLE_CHECK_EN
      check("b2b_idle_edge", i_edge, 100);
`endif
      check("b2b_first_frame", 32'(bus.frame_out), 32'h001);
      run_frame(12'h800, -1, 0, 0);
      check("b2b_second_frame", 32'(bus.frame_out), 32'h800);
      check("b2b_valid_edge", v_edge, 113);
      check("b2b_valid_count", v_count, 2);
      // reset in the middle of a frame discards it
      do_reset();
      for (int e = 0; e <= 8; e++) step(1'b1, e >= 1 ? f3[e-1] : 1'b0);
      do_reset();
      run_frame(12'h555, -1, 0, -1);
      check("abort_frame", 32'(bus.frame_out), 32'h555);
      check("abort_valid_count", v_count, 1);
      check("abort_valid_edge", v_edge, 12);
      // idle error followed by a clean frame
      do_reset();
      run_frame(12'hA5C, -1, 0, 50);
      check("idle_frame_kept", 32'(bus.frame_out), 32'hA5C);
`ifdef RX_FRAME_IDLE_CHECK_EN
      check("idle_err_edge", i_edge, 100);
      i_edge = -1;
`endif
      run_frame(12'h555, -1, 0, -1);
`ifdef RX_FRAME_IDLE_CHECK_EN
      check("idle_clean_frame", i_edge, -1);
`endif
      // random enable and data against the model
      do_reset();
      repeat (800) step($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)));
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish, compared %0d", compared);
      $fatal(1, "timeout");
   end
endmodule
